// File: rtl/ram_pkg.sv
// Shared definitions for the simple dual-port RAM family.
//   RD_LAT_MIN / RD_LAT_MAX : legal read-latency values (1 and 2)
//   BYTE_W                  : byte-lane width in bits
//   byte_parity()           : even-parity bit of one byte (byte ^ parity has even weight)
package ram_pkg;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;
  localparam int unsigned BYTE_W     = 8;

  function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return pipeline for ram_sdp_pipe.
// Carries valid, data, range error and per-byte parity error through Lat register stages.
// Data registers only load on a valid beat so the output word holds between reads; the
// error flags are forced low on non-valid beats so they are always qualified by valid.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset (flushes every stage)
//   vld_i, data_i          read beat entering the pipe and its word
//   err_i, perr_i          out-of-range flag and per-byte parity error of that beat
//   vld_o, data_o          beat leaving the pipe after Lat cycles, held data
//   err_o, perr_o          flags aligned with vld_o
module ram_rd_pipe #(
  parameter int unsigned Lat   = 1,
  parameter int unsigned Width = 32,
  parameter int unsigned Nb    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             vld_i,
  input  logic [Width-1:0] data_i,
  input  logic             err_i,
  input  logic [Nb-1:0]    perr_i,
  output logic             vld_o,
  output logic [Width-1:0] data_o,
  output logic             err_o,
  output logic [Nb-1:0]    perr_o
);

  logic [Lat-1:0]   vld_q;
  logic [Lat-1:0]   err_q;
  logic [Width-1:0] data_q [Lat];
  logic [Nb-1:0]    perr_q [Lat];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < Lat; i++) begin
        data_q[i] <= '0;
        perr_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= vld_i;
      err_q[0]  <= vld_i & err_i;
      perr_q[0] <= vld_i ? perr_i : '0;
      if (vld_i) begin
        data_q[0] <= data_i;
      end
      for (int i = 1; i < Lat; i++) begin
        vld_q[i]  <= vld_q[i-1];
        err_q[i]  <= err_q[i-1];
        perr_q[i] <= perr_q[i-1];
        if (vld_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign vld_o  = vld_q[Lat-1];
  assign err_o  = err_q[Lat-1];
  assign data_o = data_q[Lat-1];
  assign perr_o = perr_q[Lat-1];

endmodule

// File: rtl/ram_sdp_pipe.sv
// Parametrised simple dual-port RAM (one write port, one read port, single clock) with
// byte-enable writes, RD_LAT-cycle read latency, valid qualification, a same-address
// collision policy and address range checking.
//
// Timing: a read presented while the clock edge that samples it occurs returns o_rd_vld
// and o_rd_data RD_LAT edges later, counting that sampling edge (RD_LAT=1 -> visible
// right after the sampling edge). o_wr_err is likewise visible right after the edge
// that sampled the bad write.
//
// Optional feature: define RAM_PARITY_EN to store one even-parity bit per byte lane and
// report per-byte mismatches on o_rd_perr. Without it o_rd_perr is tied to 0 and
// i_perr_inj is ignored. The port list is the same in both builds.
//
// Ports:
//   i_sys_clk, i_rst_n    clock, asynchronous active-low reset (array is not reset)
//   i_wr, i_wr_addr       write strobe and address
//   i_wr_data, i_wr_be    write word and byte enables (bit k covers data[8k+7:8k])
//   i_perr_inj            invert stored parity of the enabled bytes on this write
//   i_rd, i_rd_addr       read strobe and address
//   o_rd_data, o_rd_vld   read word (held between reads) and its valid pulse
//   o_wr_err              pulse: write address was >= DEPTH, write dropped
//   o_rd_err              with o_rd_vld: read address was >= DEPTH, data forced to 0
//   o_rd_perr             per-byte parity error, qualified by o_rd_vld
module ram_sdp_pipe
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned WR_FIRST = 1,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned NB      = WIDTH / BYTE_W
) (
  input  logic             i_sys_clk,
  input  logic             i_rst_n,
  input  logic             i_wr,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [NB-1:0]    i_wr_be,
  input  logic             i_perr_inj,
  input  logic             i_rd,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_vld,
  output logic             o_wr_err,
  output logic             o_rd_err,
  output logic [NB-1:0]    o_rd_perr
);

  // Any value other than 2 falls back to the single-register read path.
  localparam int unsigned LAT = (RD_LAT == RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;

  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_ok;
  logic [AW-1:0]    rd_idx;
  logic             wr_first_hit;
  logic [WIDTH-1:0] rd_raw;
  logic [WIDTH-1:0] rd_word;
  logic [NB-1:0]    rd_perr;
  logic             wr_err_q;

  assign wr_in_range = {1'b0, i_wr_addr} < DEPTH_LIM;
  assign rd_in_range = {1'b0, i_rd_addr} < DEPTH_LIM;
  assign wr_ok       = i_wr & wr_in_range;

  // Keep the array index legal even when the request is out of range.
  assign rd_idx = rd_in_range ? i_rd_addr : '0;

  assign wr_first_hit = (WR_FIRST != 0) && wr_ok && i_rd && rd_in_range &&
                        (i_wr_addr == i_rd_addr);

  // Storage: contents survive reset, so no reset branch here.
  always_ff @(posedge i_sys_clk) begin
    if (wr_ok) begin
      for (int k = 0; k < NB; k++) begin
        if (i_wr_be[k]) begin
          mem_q[i_wr_addr][k*BYTE_W +: BYTE_W] <= i_wr_data[k*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read word with write-first bypass of the enabled bytes; the array itself still
  // holds the pre-write word on this edge, which gives read-first for free.
  always_comb begin
    rd_raw = mem_q[rd_idx];
    if (wr_first_hit) begin
      for (int k = 0; k < NB; k++) begin
        if (i_wr_be[k]) begin
          rd_raw[k*BYTE_W +: BYTE_W] = i_wr_data[k*BYTE_W +: BYTE_W];
        end
      end
    end
    rd_word = rd_in_range ? rd_raw : '0;
  end

`ifdef RAM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] wr_par;
  logic [NB-1:0] rd_par;

  always_comb begin
    wr_par = '0;
    for (int k = 0; k < NB; k++) begin
      wr_par[k] = byte_parity(i_wr_data[k*BYTE_W +: BYTE_W]) ^ i_perr_inj;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (wr_ok) begin
      for (int k = 0; k < NB; k++) begin
        if (i_wr_be[k]) begin
          par_q[i_wr_addr][k] <= wr_par[k];
        end
      end
    end
  end

  // Parity follows the same bypass as the data so a collision checks consistently.
  always_comb begin
    rd_par = par_q[rd_idx];
    if (wr_first_hit) begin
      for (int k = 0; k < NB; k++) begin
        if (i_wr_be[k]) begin
          rd_par[k] = wr_par[k];
        end
      end
    end
    rd_perr = '0;
    for (int k = 0; k < NB; k++) begin
      rd_perr[k] = rd_in_range && (byte_parity(rd_raw[k*BYTE_W +: BYTE_W]) != rd_par[k]);
    end
  end
`else
  logic unused_perr_inj;
  assign unused_perr_inj = i_perr_inj;
  assign rd_perr         = '0;
`endif

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= i_wr & ~wr_in_range;
    end
  end

  assign o_wr_err = wr_err_q;

  ram_rd_pipe #(
    .Lat   (LAT),
    .Width (WIDTH),
    .Nb    (NB)
  ) u_rd_pipe (
    .clk_i  (i_sys_clk),
    .rst_ni (i_rst_n),
    .vld_i  (i_rd),
    .data_i (rd_word),
    .err_i  (~rd_in_range),
    .perr_i (rd_perr),
    .vld_o  (o_rd_vld),
    .data_o (o_rd_data),
    .err_o  (o_rd_err),
    .perr_o (o_rd_perr)
  );

endmodule

// File: tb/tb_ram_sdp_pipe.sv
// Directed bench for ram_sdp_pipe. Two instances share clock and reset:
//   dut A: DEPTH=32, RD_LAT=1, WR_FIRST=1
//   dut B: DEPTH=24, RD_LAT=2, WR_FIRST=0 (exercises out-of-range addresses 24..31)
module tb_ram_sdp_pipe;

  logic clk;
  logic rst_n;

  logic        a_wr, a_rd, a_perr_inj;
  logic [4:0]  a_wr_addr, a_rd_addr;
  logic [31:0] a_wr_data, a_rd_data;
  logic [3:0]  a_wr_be, a_rd_perr;
  logic        a_rd_vld, a_wr_err, a_rd_err;

  logic        b_wr, b_rd, b_perr_inj;
  logic [4:0]  b_wr_addr, b_rd_addr;
  logic [31:0] b_wr_data, b_rd_data;
  logic [3:0]  b_wr_be, b_rd_perr;
  logic        b_rd_vld, b_wr_err, b_rd_err;

  int checks   = 0;
  int failures = 0;

  ram_sdp_pipe #(
    .DEPTH    (32),
    .WIDTH    (32),
    .RD_LAT   (1),
    .WR_FIRST (1)
  ) u_dut_a (
    .i_sys_clk  (clk),
    .i_rst_n    (rst_n),
    .i_wr       (a_wr),
    .i_wr_addr  (a_wr_addr),
    .i_wr_data  (a_wr_data),
    .i_wr_be    (a_wr_be),
    .i_perr_inj (a_perr_inj),
    .i_rd       (a_rd),
    .i_rd_addr  (a_rd_addr),
    .o_rd_data  (a_rd_data),
    .o_rd_vld   (a_rd_vld),
    .o_wr_err   (a_wr_err),
    .o_rd_err   (a_rd_err),
    .o_rd_perr  (a_rd_perr)
  );

  ram_sdp_pipe #(
    .DEPTH    (24),
    .WIDTH    (32),
    .RD_LAT   (2),
    .WR_FIRST (0)
  ) u_dut_b (
    .i_sys_clk  (clk),
    .i_rst_n    (rst_n),
    .i_wr       (b_wr),
    .i_wr_addr  (b_wr_addr),
    .i_wr_data  (b_wr_data),
    .i_wr_be    (b_wr_be),
    .i_perr_inj (b_perr_inj),
    .i_rd       (b_rd),
    .i_rd_addr  (b_rd_addr),
    .o_rd_data  (b_rd_data),
    .o_rd_vld   (b_rd_vld),
    .o_wr_err   (b_wr_err),
    .o_rd_err   (b_rd_err),
    .o_rd_perr  (b_rd_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus on A; returns 1 time unit after the edge.
  task automatic a_cycle(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic inj, input logic rd,
                         input logic [4:0] ra);
    a_wr = wr; a_wr_addr = wa; a_wr_data = wd; a_wr_be = be; a_perr_inj = inj;
    a_rd = rd; a_rd_addr = ra;
    @(posedge clk);
    #1;
    a_wr = 1'b0; a_rd = 1'b0; a_perr_inj = 1'b0;
  endtask

  task automatic b_cycle(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic rd, input logic [4:0] ra);
    b_wr = wr; b_wr_addr = wa; b_wr_data = wd; b_wr_be = be; b_perr_inj = 1'b0;
    b_rd = rd; b_rd_addr = ra;
    @(posedge clk);
    #1;
    b_wr = 1'b0; b_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_wr = 0; a_rd = 0; a_perr_inj = 0; a_wr_addr = 0; a_rd_addr = 0; a_wr_data = 0; a_wr_be = 0;
    b_wr = 0; b_rd = 0; b_perr_inj = 0; b_wr_addr = 0; b_rd_addr = 0; b_wr_data = 0; b_wr_be = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_rd_data, a_rd_vld, a_wr_err, a_rd_err, a_rd_perr} !== 39'd0) begin
      failures++;
      $display("FAIL reset_a: got data=%h vld=%b werr=%b rerr=%b perr=%b, want all 0",
               a_rd_data, a_rd_vld, a_wr_err, a_rd_err, a_rd_perr);
    end
    checks++;
    if ({b_rd_data, b_rd_vld, b_wr_err, b_rd_err, b_rd_perr} !== 39'd0) begin
      failures++;
      $display("FAIL reset_b: got data=%h vld=%b werr=%b rerr=%b perr=%b, want all 0",
               b_rd_data, b_rd_vld, b_wr_err, b_rd_err, b_rd_perr);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_read();
    for (int i = 0; i < 32; i++) a_cycle(1, 5'(i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 24; i++) b_cycle(1, 5'(i), 32'(i + 1), 4'hF, 0, 0);
    checks++;
    if (a_rd_vld !== 1'b0 || b_rd_vld !== 1'b0) begin
      failures++;
      $display("FAIL idle_vld: got a=%b b=%b, want 0 0", a_rd_vld, b_rd_vld);
    end
    // A: latency 1, back-to-back reads.
    for (int i = 0; i < 32; i++) begin
      a_cycle(0, 0, 0, 0, 0, 1, 5'(i));
      checks++;
      if (a_rd_vld !== 1'b1 || a_rd_data !== 32'(i + 1) || a_rd_err !== 1'b0 ||
          a_rd_perr !== 4'h0) begin
        failures++;
        $display("FAIL fill_read_a[%0d]: got vld=%b data=%h err=%b perr=%b, want 1 %h 0 0",
                 i, a_rd_vld, a_rd_data, a_rd_err, a_rd_perr, 32'(i + 1));
      end
    end
    // B: latency 2, back-to-back reads; result of read i-1 shows after read i is sampled.
    for (int i = 0; i <= 24; i++) begin
      if (i < 24) b_cycle(0, 0, 0, 0, 1, 5'(i));
      else        b_cycle(0, 0, 0, 0, 0, 0);
      checks++;
      if (i == 0) begin
        if (b_rd_vld !== 1'b0) begin
          failures++;
          $display("FAIL lat2_early: got vld=%b, want 0", b_rd_vld);
        end
      end else if (b_rd_vld !== 1'b1 || b_rd_data !== 32'(i) || b_rd_err !== 1'b0) begin
        failures++;
        $display("FAIL fill_read_b[%0d]: got vld=%b data=%h err=%b, want 1 %h 0",
                 i - 1, b_rd_vld, b_rd_data, b_rd_err, 32'(i));
      end
    end
    b_cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (b_rd_vld !== 1'b0 || b_rd_data !== 32'd24) begin
      failures++;
      $display("FAIL hold_b: got vld=%b data=%h, want 0 00000018", b_rd_vld, b_rd_data);
    end
  endtask

  task automatic test_byte_enable();
    a_cycle(1, 5, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    a_cycle(1, 5, 32'h11223344, 4'b0101, 0, 0, 0);
    checks++;
    if (a_wr_err !== 1'b0) begin
      failures++;
      $display("FAIL wr_err_inrange: got %b, want 0", a_wr_err);
    end
    a_cycle(0, 0, 0, 0, 0, 1, 5);
    checks++;
    if (a_rd_vld !== 1'b1 || a_rd_data !== 32'hAA22CC44) begin
      failures++;
      $display("FAIL byte_enable: got vld=%b data=%h, want 1 aa22cc44", a_rd_vld, a_rd_data);
    end
    a_cycle(1, 5, 32'hFFFFFFFF, 4'b0000, 0, 0, 0);
    a_cycle(0, 0, 0, 0, 0, 1, 5);
    checks++;
    if (a_rd_data !== 32'hAA22CC44) begin
      failures++;
      $display("FAIL be_zero: got data=%h, want aa22cc44", a_rd_data);
    end
  endtask

  task automatic test_collision();
    a_cycle(1, 7, 32'h7, 4'hF, 0, 0, 0);
    a_cycle(1, 7, 32'hDEADBEEF, 4'hF, 0, 1, 7);
    checks++;
    if (a_rd_vld !== 1'b1 || a_rd_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL coll_wr_first: got vld=%b data=%h, want 1 deadbeef", a_rd_vld, a_rd_data);
    end
    a_cycle(1, 8, 32'h12345678, 4'hF, 0, 0, 0);
    a_cycle(1, 8, 32'hAABBCCDD, 4'b0011, 0, 1, 8);
    checks++;
    if (a_rd_data !== 32'h1234CCDD) begin
      failures++;
      $display("FAIL coll_merge: got data=%h, want 1234ccdd", a_rd_data);
    end
    b_cycle(1, 7, 32'h7, 4'hF, 0, 0);
    b_cycle(1, 7, 32'hDEADBEEF, 4'hF, 1, 7);
    b_cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (b_rd_vld !== 1'b1 || b_rd_data !== 32'h00000007) begin
      failures++;
      $display("FAIL coll_rd_first: got vld=%b data=%h, want 1 00000007", b_rd_vld, b_rd_data);
    end
    b_cycle(0, 0, 0, 0, 1, 7);
    b_cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (b_rd_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL coll_rd_first_after: got data=%h, want deadbeef", b_rd_data);
    end
  endtask

  task automatic test_out_of_range();
    b_cycle(1, 30, 32'h55555555, 4'hF, 0, 0);
    checks++;
    if (b_wr_err !== 1'b1) begin
      failures++;
      $display("FAIL wr_err_pulse: got %b, want 1", b_wr_err);
    end
    b_cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (b_wr_err !== 1'b0) begin
      failures++;
      $display("FAIL wr_err_clear: got %b, want 0", b_wr_err);
    end
    b_cycle(0, 0, 0, 0, 1, 30);
    b_cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (b_rd_vld !== 1'b1 || b_rd_err !== 1'b1 || b_rd_data !== 32'd0) begin
      failures++;
      $display("FAIL rd_oor: got vld=%b err=%b data=%h, want 1 1 00000000",
               b_rd_vld, b_rd_err, b_rd_data);
    end
    for (int i = 0; i < 2; i++) begin
      b_cycle(0, 0, 0, 0, 1, (i == 0) ? 5'd6 : 5'd22);
      b_cycle(0, 0, 0, 0, 0, 0);
      checks++;
      if (b_rd_vld !== 1'b1 || b_rd_err !== 1'b0 ||
          b_rd_data !== ((i == 0) ? 32'd7 : 32'd23)) begin
        failures++;
        $display("FAIL oor_unchanged[%0d]: got vld=%b err=%b data=%h, want 1 0 %h", i,
                 b_rd_vld, b_rd_err, b_rd_data, (i == 0) ? 32'd7 : 32'd23);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    b_rd = 1; b_rd_addr = 1;
    @(posedge clk);
    #1;
    b_rd_addr = 2;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({b_rd_data, b_rd_vld, b_rd_err, b_rd_perr} !== 38'd0 || a_rd_data !== 32'd0) begin
      failures++;
      $display("FAIL rst_async: got b_data=%h b_vld=%b a_data=%h, want all 0",
               b_rd_data, b_rd_vld, a_rd_data);
    end
    b_rd_addr = 3;
    @(posedge clk);
    #1;
    b_rd = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (b_rd_vld !== 1'b0 || a_rd_vld !== 1'b0 || b_rd_data !== 32'd0) begin
        failures++;
        $display("FAIL rst_flush[%0d]: got b_vld=%b a_vld=%b b_data=%h, want 0 0 0",
                 i, b_rd_vld, a_rd_vld, b_rd_data);
      end
    end
    b_cycle(0, 0, 0, 0, 1, 1);
    b_cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (b_rd_vld !== 1'b1 || b_rd_data !== 32'd2) begin
      failures++;
      $display("FAIL retain_b: got vld=%b data=%h, want 1 00000002", b_rd_vld, b_rd_data);
    end
    a_cycle(0, 0, 0, 0, 0, 1, 5);
    checks++;
    if (a_rd_vld !== 1'b1 || a_rd_data !== 32'hAA22CC44) begin
      failures++;
      $display("FAIL retain_a: got vld=%b data=%h, want 1 aa22cc44", a_rd_vld, a_rd_data);
    end
  endtask

  task automatic test_parity();
    logic [3:0] exp_perr;
`ifdef RAM_PARITY_EN
    exp_perr = 4'b0010;
`else
    exp_perr = 4'b0000;
`endif
    a_cycle(1, 3, 32'h0000AB00, 4'b0010, 1, 0, 0);
    a_cycle(0, 0, 0, 0, 0, 1, 3);
    checks++;
    if (a_rd_vld !== 1'b1 || a_rd_data !== 32'h0000AB04 || a_rd_perr !== exp_perr) begin
      failures++;
      $display("FAIL parity_inj: got vld=%b data=%h perr=%b, want 1 0000ab04 %b",
               a_rd_vld, a_rd_data, a_rd_perr, exp_perr);
    end
    a_cycle(0, 0, 0, 0, 0, 1, 4);
    checks++;
    if (a_rd_data !== 32'd5 || a_rd_perr !== 4'b0000) begin
      failures++;
      $display("FAIL parity_clean: got data=%h perr=%b, want 00000005 0000",
               a_rd_data, a_rd_perr);
    end
    a_cycle(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (a_rd_perr !== 4'b0000 || a_rd_vld !== 1'b0) begin
      failures++;
      $display("FAIL perr_qual: got vld=%b perr=%b, want 0 0000", a_rd_vld, a_rd_perr);
    end
  endtask

  initial begin
    test_reset();
    test_fill_read();
    test_byte_enable();
    test_collision();
    test_out_of_range();
    test_reset_mid_read();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
